// File: rtl/tick_timer_pkg.sv
// Shared types for the tick timer: command opcodes, channel modes/states and
// the registered command packet.
package tick_timer_pkg;

  // The command packet is sized for the largest supported configuration
  // (16 channels, 32-bit count); narrower builds zero-extend into it.
  localparam int PKT_CHAN_W = 4;
  localparam int PKT_DATA_W = 32;

  typedef enum logic [1:0] {
    CMD_START        = 2'd0,
    CMD_STOP         = 2'd1,
    CMD_SET_PRESCALE = 2'd2,
    CMD_SET_RELOAD   = 2'd3
  } cmd_t;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_t;

  typedef struct packed {
    cmd_t                  op;
    logic [PKT_CHAN_W-1:0] chan;
    mode_t                 mode;
    logic [PKT_DATA_W-1:0] data;
  } cmd_packet_t;

  function automatic cmd_packet_t make_packet(
    input logic [1:0]            op,
    input logic [PKT_CHAN_W-1:0] chan,
    input logic                  mode,
    input logic [PKT_DATA_W-1:0] data
  );
    cmd_packet_t p;
    p.op   = cmd_t'(op);
    p.chan = chan;
    p.mode = mode_t'(mode);
    p.data = data;
    return p;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload register, down-counter, IDLE/RUN FSM and a
// registered 1-cycle tick driven by the shared prescaler strobe.
module timer_channel
  import tick_timer_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   strobe_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   set_reload_i,
  input  mode_t                  mode_i,
  input  logic [COUNT_WIDTH-1:0] data_i,
  output logic                   tick_o,
  output chan_state_t            state_o
);

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] reload_q;
  logic [COUNT_WIDTH-1:0] count_q;
  mode_t                  mode_q;
  chan_state_t            state_q;
  logic                   tick_q;

  // START and STOP take priority over an expiry in the same cycle, which
  // suppresses the tick that expiry would otherwise have produced.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      reload_q <= '0;
      count_q  <= '0;
      mode_q   <= MODE_PERIODIC;
      state_q  <= CH_IDLE;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (set_reload_i) begin
        reload_q <= data_i;
      end
      if (start_i) begin
        count_q <= reload_q;
        mode_q  <= mode_i;
        state_q <= CH_RUN;
      end else if (stop_i) begin
        state_q <= CH_IDLE;
      end else if (state_q == CH_RUN && strobe_i) begin
        if (count_q == '0) begin
          tick_q <= 1'b1;
          if (mode_q == MODE_ONESHOT) begin
            state_q <= CH_IDLE;
          end else begin
            count_q <= reload_q;
          end
        end else begin
          count_q <= count_q - ONE;
        end
      end
    end
  end

  assign tick_o  = tick_q;
  assign state_o = state_q;

endmodule

// File: rtl/tick_timer_ctrl.sv
// Multi-channel tick scheduler: command stage + decode, shared prescaler and
// N timer_channel instances. Build with TICK_TIMER_IRQ_LATCH_EN for sticky irq_o.
module tick_timer_ctrl
  import tick_timer_pkg::*;
#(
  parameter int N_CHANNELS     = 4,
  parameter int PRESCALE_WIDTH = 16,
  parameter int COUNT_WIDTH    = 32,
  localparam int CHAN_W        = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_op_i,
  input  logic [CHAN_W-1:0]      cmd_chan_i,
  input  logic                   cmd_mode_i,
  input  logic [COUNT_WIDTH-1:0] cmd_data_i,
`ifdef TICK_TIMER_IRQ_LATCH_EN
  input  logic [N_CHANNELS-1:0]  irq_clear_i,
`endif
  output logic [N_CHANNELS-1:0]  tick_o,
  output logic [N_CHANNELS-1:0]  running_o,
  output logic [N_CHANNELS-1:0]  irq_o
);

  // Handshake: a command transfers on a cycle where cmd_valid_i && cmd_ready_o.
  // It sits in the stage for exactly one cycle (the apply cycle), during which
  // cmd_ready_o is low; the effect is visible after the following edge.
  logic        stage_full_q;
  cmd_packet_t stage_q;
  logic        accept;

  assign accept      = cmd_valid_i && !stage_full_q;
  assign cmd_ready_o = !stage_full_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_full_q <= 1'b0;
      stage_q      <= '0;
    end else begin
      stage_full_q <= accept;
      if (accept) begin
        stage_q <= make_packet(cmd_op_i, PKT_CHAN_W'(cmd_chan_i), cmd_mode_i,
                               PKT_DATA_W'(cmd_data_i));
      end
    end
  end

  // Shared prescaler: counts 0..divisor and strobes on the terminal count.
  logic                      apply_prescale;
  logic [PRESCALE_WIDTH-1:0] div_q, div_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                      strobe;

  assign apply_prescale = stage_full_q && (stage_q.op == CMD_SET_PRESCALE);

  always_comb begin
    div_d  = div_q;
    pcnt_d = pcnt_q;
    strobe = 1'b0;
    if (apply_prescale) begin
      div_d  = stage_q.data[PRESCALE_WIDTH-1:0];
      pcnt_d = '0;
    end else if (pcnt_q == div_q) begin
      strobe = 1'b1;
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q  <= '0;
      pcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      pcnt_q <= pcnt_d;
    end
  end

  // Per-channel decode; commands naming a nonexistent channel hit nothing.
  chan_state_t chan_state [N_CHANNELS];

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
    logic hit;
    logic start_en;
    logic stop_en;
    logic reload_en;

    assign hit       = stage_full_q && (stage_q.chan == PKT_CHAN_W'(i));
    assign start_en  = hit && (stage_q.op == CMD_START);
    assign stop_en   = hit && (stage_q.op == CMD_STOP);
    assign reload_en = hit && (stage_q.op == CMD_SET_RELOAD);

    timer_channel #(
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .strobe_i     (strobe),
      .start_i      (start_en),
      .stop_i       (stop_en),
      .set_reload_i (reload_en),
      .mode_i       (stage_q.mode),
      .data_i       (stage_q.data[COUNT_WIDTH-1:0]),
      .tick_o       (tick_o[i]),
      .state_o      (chan_state[i])
    );

    assign running_o[i] = (chan_state[i] == CH_RUN);
  end

`ifdef TICK_TIMER_IRQ_LATCH_EN
  // Sticky pending bits: a tick in the same cycle beats a clear.
  logic [N_CHANNELS-1:0] irq_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_q <= '0;
    end else begin
      irq_q <= tick_o | (irq_q & ~irq_clear_i);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = tick_o;
`endif

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Directed bench for tick_timer_ctrl: a per-cycle vector table plus
// hand-written reset and irq sequences.
module tb_tick_timer_ctrl;
  import tick_timer_pkg::*;

  logic        clk_i       = 1'b0;
  logic        rst_n_i     = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i    = 2'd0;
  logic [1:0]  cmd_chan_i  = 2'd0;
  logic        cmd_mode_i  = 1'b0;
  logic [31:0] cmd_data_i  = 32'd0;
  logic [3:0]  tick_o;
  logic [3:0]  running_o;
  logic [3:0]  irq_o;
`ifdef TICK_TIMER_IRQ_LATCH_EN
  logic [3:0]  irq_clear_i = 4'b0000;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  tick_timer_ctrl #(
    .N_CHANNELS     (4),
    .PRESCALE_WIDTH (16),
    .COUNT_WIDTH    (32)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_chan_i  (cmd_chan_i),
    .cmd_mode_i  (cmd_mode_i),
    .cmd_data_i  (cmd_data_i),
`ifdef TICK_TIMER_IRQ_LATCH_EN
    .irq_clear_i (irq_clear_i),
`endif
    .tick_o      (tick_o),
    .running_o   (running_o),
    .irq_o       (irq_o)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [1:0]  chan;
    logic        mode;
    logic [31:0] data;
    logic        exp_ready;
    logic [3:0]  exp_tick;
    logic [3:0]  exp_run;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [1:0] op, input logic [1:0] ch,
                              input logic md, input logic [31:0] d, input logic rdy,
                              input logic [3:0] tk, input logic [3:0] rn);
    vec_t e;
    e.valid = v; e.op = op; e.chan = ch; e.mode = md; e.data = d;
    e.exp_ready = rdy; e.exp_tick = tk; e.exp_run = rn;
    vecs.push_back(e);
  endfunction

  function automatic void idle(input int n, input logic [3:0] rn);
    for (int j = 0; j < n; j++) add(1'b0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b1, 4'b0000, rn);
  endfunction

  function automatic void tick(input logic [3:0] tk, input logic [3:0] rn);
    add(1'b0, 2'd0, 2'd0, 1'b0, 32'd0, 1'b1, tk, rn);
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present a command and hold it until accepted (bounded)
  task automatic send_cmd(input logic [1:0] op, input logic [1:0] ch, input logic md,
                          input logic [31:0] d);
    int waited;
    waited = 0;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_chan_i = ch; cmd_mode_i = md; cmd_data_i = d;
    while (!cmd_ready_o && waited < 8) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (!cmd_ready_o) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_cmd timeout: ready=%b expected 1", cmd_ready_o);
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    // ch0 reload 3 periodic at div 0: tick every 4 cycles
    add(1'b1, CMD_SET_RELOAD, 2'd0, 1'b0, 32'd3, 1'b0, 4'b0000, 4'b0000);   // 0
    idle(1, 4'b0000);                                                        // 1
    add(1'b1, CMD_START, 2'd0, 1'b0, 32'd0, 1'b0, 4'b0000, 4'b0000);        // 2
    idle(4, 4'b0001);                                                        // 3-6
    tick(4'b0001, 4'b0001);                                                  // 7
    idle(3, 4'b0001);                                                        // 8-10
    tick(4'b0001, 4'b0001);                                                  // 11
    idle(2, 4'b0001);                                                        // 12-13
    // STOP applied in the expiry cycle: no tick
    add(1'b1, CMD_STOP, 2'd0, 1'b0, 32'd0, 1'b0, 4'b0000, 4'b0001);         // 14
    idle(1, 4'b0000);                                                        // 15
    // back-to-back valid: ready toggles
    add(1'b1, CMD_SET_RELOAD, 2'd3, 1'b0, 32'd7, 1'b0, 4'b0000, 4'b0000);   // 16
    add(1'b1, CMD_SET_RELOAD, 2'd3, 1'b0, 32'd9, 1'b1, 4'b0000, 4'b0000);   // 17
    add(1'b1, CMD_SET_RELOAD, 2'd3, 1'b0, 32'd9, 1'b0, 4'b0000, 4'b0000);   // 18
    add(1'b1, CMD_SET_RELOAD, 2'd3, 1'b0, 32'd2, 1'b1, 4'b0000, 4'b0000);   // 19
    add(1'b1, CMD_SET_RELOAD, 2'd3, 1'b0, 32'd2, 1'b0, 4'b0000, 4'b0000);   // 20
    idle(1, 4'b0000);                                                        // 21
    // div 9, ch1 reload 0 one-shot
    add(1'b1, CMD_SET_PRESCALE, 2'd0, 1'b0, 32'd9, 1'b0, 4'b0000, 4'b0000); // 22
    idle(1, 4'b0000);                                                        // 23
    add(1'b1, CMD_START, 2'd1, 1'b1, 32'd0, 1'b0, 4'b0000, 4'b0000);        // 24
    idle(8, 4'b0010);                                                        // 25-32
    tick(4'b0010, 4'b0000);                                                  // 33
    idle(12, 4'b0000);                                                       // 34-45
    // ch2 reload 5, SET_RELOAD 1 mid-count
    add(1'b1, CMD_SET_PRESCALE, 2'd0, 1'b0, 32'd0, 1'b0, 4'b0000, 4'b0000); // 46
    idle(1, 4'b0000);                                                        // 47
    add(1'b1, CMD_SET_RELOAD, 2'd2, 1'b0, 32'd5, 1'b0, 4'b0000, 4'b0000);   // 48
    idle(1, 4'b0000);                                                        // 49
    add(1'b1, CMD_START, 2'd2, 1'b0, 32'd0, 1'b0, 4'b0000, 4'b0000);        // 50
    idle(2, 4'b0100);                                                        // 51-52
    add(1'b1, CMD_SET_RELOAD, 2'd2, 1'b0, 32'd1, 1'b0, 4'b0000, 4'b0100);   // 53
    idle(3, 4'b0100);                                                        // 54-56
    tick(4'b0100, 4'b0100);                                                  // 57
    idle(1, 4'b0100);                                                        // 58
    tick(4'b0100, 4'b0100);                                                  // 59
    idle(1, 4'b0100);                                                        // 60
    tick(4'b0100, 4'b0100);                                                  // 61
    add(1'b1, CMD_STOP, 2'd2, 1'b0, 32'd0, 1'b0, 4'b0000, 4'b0100);         // 62
    idle(3, 4'b0000);                                                        // 63-65

    // reset state
    #2 rst_n_i = 1'b0;
    #1;
    check("reset_state", {cmd_ready_o, tick_o, running_o, irq_o}, {1'b1, 12'h000});
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      cmd_valid_i = vecs[k].valid;
      cmd_op_i    = vecs[k].op;
      cmd_chan_i  = vecs[k].chan;
      cmd_mode_i  = vecs[k].mode;
      cmd_data_i  = vecs[k].data;
      @(posedge clk_i); #1;
`ifdef TICK_TIMER_IRQ_LATCH_EN
      check($sformatf("vec%0d rdy/tick/run", k), {cmd_ready_o, tick_o, running_o},
            {vecs[k].exp_ready, vecs[k].exp_tick, vecs[k].exp_run});
`else
      check($sformatf("vec%0d rdy/tick/run/irq", k), {cmd_ready_o, tick_o, running_o, irq_o},
            {vecs[k].exp_ready, vecs[k].exp_tick, vecs[k].exp_run, vecs[k].exp_tick});
`endif
    end
    cmd_valid_i = 1'b0;

    // reset mid-count with a command pending in the stage
    send_cmd(CMD_START, 2'd0, 1'b0, 32'd0);
    @(posedge clk_i); #1;
    check("pre_reset running", {28'd0, running_o}, 32'h1);
    repeat (2) begin @(posedge clk_i); #1; end
    cmd_valid_i = 1'b1; cmd_op_i = CMD_START; cmd_chan_i = 2'd1; cmd_mode_i = 1'b1;
    cmd_data_i = 32'd0;
    @(posedge clk_i); #1;
    check("pending ready", {31'd0, cmd_ready_o}, 32'h0);
    #2 rst_n_i = 1'b0;
    cmd_valid_i = 1'b0;
    #1;
    check("async_reset outputs", {cmd_ready_o, tick_o, running_o, irq_o}, {1'b1, 12'h000});
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
      check($sformatf("dropped_cmd c%0d", k), {cmd_ready_o, tick_o, running_o}, {1'b1, 8'h00});
    end

    // reload and divisor back at 0 after reset: tick on every strobe
    send_cmd(CMD_START, 2'd0, 1'b0, 32'd0);
    @(posedge clk_i); #1;
    check("reload0 apply tick/run", {tick_o, running_o}, {4'b0000, 4'b0001});
    @(posedge clk_i); #1;
    check("reload0 tick1", {28'd0, tick_o}, 32'h1);
    @(posedge clk_i); #1;
    check("reload0 tick2", {28'd0, tick_o}, 32'h1);
`ifdef TICK_TIMER_IRQ_LATCH_EN
    check("irq set by tick", {28'd0, irq_o}, 32'h1);
    irq_clear_i = 4'b0001;
    @(posedge clk_i); #1;
    check("irq set beats clear", {28'd0, irq_o}, 32'h1);
    irq_clear_i = 4'b0000;
`else
    check("irq follows tick", {28'd0, irq_o}, 32'h1);
`endif
    send_cmd(CMD_STOP, 2'd0, 1'b0, 32'd0);
    @(posedge clk_i); #1;
    check("stop apply tick/run", {24'd0, tick_o, running_o}, 32'h0);
`ifdef TICK_TIMER_IRQ_LATCH_EN
    @(posedge clk_i); #1;
    check("irq sticky", {28'd0, irq_o}, 32'h1);
    irq_clear_i = 4'b0001;
    @(posedge clk_i); #1;
    check("irq cleared", {28'd0, irq_o}, 32'h0);
    irq_clear_i = 4'b0000;
`else
    check("irq low after stop", {28'd0, irq_o}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
